// File: rtl/bsg_wormhole_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_wormhole_packet_tx
//  Purpose  : Wormhole link packetizer. Emits one header flit and then len
//             payload flits through a single registered valid/yumi slot.
//  Option   : BSG_WORMHOLE_PACKET_TX_STATS_EN adds the pkt_count_o counter.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_wormhole_packet_tx #(
   parameter int flit_width_p = 16,
   parameter int cord_width_p = 4,
   parameter int len_width_p  = 3
) (
   input  logic                                        clk_i,
   input  logic                                        reset_n_i,
   input  logic                                        hdr_v_i,
   input  logic [cord_width_p-1:0]                     hdr_dest_i,
   input  logic [len_width_p-1:0]                      hdr_len_i,
   input  logic [flit_width_p-cord_width_p-len_width_p-1:0] hdr_user_i,
   output logic                                        hdr_ready_o,
   input  logic                                        data_v_i,
   input  logic [flit_width_p-1:0]                     data_i,
   output logic                                        data_ready_o,
   output logic                                        link_v_o,
   output logic [flit_width_p-1:0]                     link_data_o,
   input  logic                                        link_yumi_i,
   output logic                                        busy_o,
   output logic                                        pkt_done_o
`ifdef BSG_WORMHOLE_PACKET_TX_STATS_EN
   ,
   output logic [15:0]                                 pkt_count_o
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_n;
   logic [len_width_p-1:0]    r_count;
   logic                      r_last;
   logic                      r_link_v;
   logic [flit_width_p-1:0]   r_link_data;
   logic                      r_pkt_done;

   logic                      w_slot_free;
   logic                      w_yumi;
   logic                      w_hdr_hs;
   logic                      w_data_hs;
   logic                      w_count_is_one;
   logic [flit_width_p-1:0]   w_hdr_flit;

   assign w_hdr_flit     = {hdr_user_i, hdr_len_i, hdr_dest_i};
   assign w_slot_free    = ~r_link_v | link_yumi_i;
   // A yumi with nothing presented is illegal and must not disturb state.
   assign w_yumi         = link_yumi_i & r_link_v;
   assign w_count_is_one = (r_count == len_width_p'(1));

   always_comb begin
      hdr_ready_o  = 1'b0;
      data_ready_o = 1'b0;
      w_state_n    = r_state;
      case (r_state)
         IDLE: begin
            // Gated by reset so that every output reads zero while held in reset.
            hdr_ready_o = w_slot_free & reset_n_i;
            if (hdr_v_i && hdr_ready_o && (hdr_len_i != '0)) begin
               w_state_n = BODY;
            end
         end
         BODY: begin
            data_ready_o = w_slot_free;
            if (data_v_i && w_slot_free && w_count_is_one) begin
               w_state_n = IDLE;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign w_hdr_hs  = hdr_v_i  & hdr_ready_o;
   assign w_data_hs = data_v_i & data_ready_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_last      <= 1'b0;
         r_link_v    <= 1'b0;
         r_link_data <= '0;
         r_pkt_done  <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_pkt_done <= w_yumi & r_last;
         if (w_hdr_hs) begin
            r_link_v    <= 1'b1;
            r_link_data <= w_hdr_flit;
            r_count     <= hdr_len_i;
            r_last      <= (hdr_len_i == '0);
         end else if (w_data_hs) begin
            r_link_v    <= 1'b1;
            r_link_data <= data_i;
            r_count     <= r_count - len_width_p'(1);
            r_last      <= w_count_is_one;
         end else if (w_yumi) begin
            r_link_v    <= 1'b0;
         end
      end
   end

   assign link_v_o    = r_link_v;
   assign link_data_o = r_link_data;
   assign pkt_done_o  = r_pkt_done;
   assign busy_o      = (r_state != IDLE) | r_link_v;

`ifdef BSG_WORMHOLE_PACKET_TX_STATS_EN
   logic [15:0] r_pkt_count;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_pkt_count <= '0;
      end else if (r_pkt_done) begin
         r_pkt_count <= r_pkt_count + 16'd1;
      end
   end

   assign pkt_count_o = r_pkt_count;
`endif

`ifndef SYNTHESIS
   a_yumi_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      link_yumi_i |-> r_link_v)
      else $error("link_yumi_i asserted while link_v_o is low");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_wormhole_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_wormhole_packet_tx
//  Purpose  : Directed bench: per-cycle vector table plus hand-written
//             stall, long-packet, reset and (optional) stats sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_wormhole_packet_tx;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        hdr_v_i;
   logic [3:0]  hdr_dest_i;
   logic [2:0]  hdr_len_i;
   logic [8:0]  hdr_user_i;
   logic        hdr_ready_o;
   logic        data_v_i;
   logic [15:0] data_i;
   logic        data_ready_o;
   logic        link_v_o;
   logic [15:0] link_data_o;
   logic        link_yumi_i;
   logic        busy_o;
   logic        pkt_done_o;
`ifdef BSG_WORMHOLE_PACKET_TX_STATS_EN
   logic [15:0] pkt_count_o;
`endif

   bsg_wormhole_packet_tx dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .hdr_v_i      (hdr_v_i),
      .hdr_dest_i   (hdr_dest_i),
      .hdr_len_i    (hdr_len_i),
      .hdr_user_i   (hdr_user_i),
      .hdr_ready_o  (hdr_ready_o),
      .data_v_i     (data_v_i),
      .data_i       (data_i),
      .data_ready_o (data_ready_o),
      .link_v_o     (link_v_o),
      .link_data_o  (link_data_o),
      .link_yumi_i  (link_yumi_i),
      .busy_o       (busy_o),
      .pkt_done_o   (pkt_done_o)
`ifdef BSG_WORMHOLE_PACKET_TX_STATS_EN
      ,
      .pkt_count_o  (pkt_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        hv;
      logic [3:0]  dest;
      logic [2:0]  len;
      logic [8:0]  user;
      logic        dv;
      logic [15:0] d;
      logic        y;
      logic        e_v;
      logic [15:0] e_data;
      logic        e_hr;
      logic        e_dr;
      logic        e_done;
      logic        e_busy;
   } vec_t;

   vec_t        vecs [10];
   int          checks = 0;
   int          errors = 0;
   int          n_data = 0;
   int          n_done = 0;
   logic [15:0] cap [$];
   logic [15:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs (yumi only offered when a flit is presented),
   // settle, and record every handshake that will complete at the next edge.
   task automatic apply(input logic hv, input logic [3:0] dest, input logic [2:0] len,
                        input logic [8:0] user, input logic dv, input logic [15:0] d,
                        input logic y);
      hdr_v_i     = hv;
      hdr_dest_i  = dest;
      hdr_len_i   = len;
      hdr_user_i  = user;
      data_v_i    = dv;
      data_i      = d;
      link_yumi_i = y & link_v_o;
      #1;
      if (link_v_o && link_yumi_i) cap.push_back(link_data_o);
      if (data_v_i && data_ready_o) n_data++;
      if (pkt_done_o) n_done++;
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic check_cap(input string name);
      check({name, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
         check($sformatf("%s_flit%0d", name, i), {16'h0, cap[i]}, {16'h0, exp_q[i]});
   endtask

   initial begin
      // {hv,dest,len,user,dv,data,y, exp: v,data,hdr_rdy,data_rdy,done,busy}
      vecs[0] = '{1'b1, 4'd5, 3'd2, 9'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'hAAAA, 1'b1, 1'b1, 16'h0025, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'hBBBB, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 4'd3, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 4'd4, 3'd1, 9'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0014, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};

      reset_n_i   = 1'b0;
      hdr_v_i     = 1'b0;
      hdr_dest_i  = '0;
      hdr_len_i   = '0;
      hdr_user_i  = '0;
      data_v_i    = 1'b0;
      data_i      = '0;
      link_yumi_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("reset_outputs",
            {11'h0, link_v_o, link_data_o, hdr_ready_o, data_ready_o, busy_o, pkt_done_o}, 32'h0);
      reset_n_i = 1'b1;

      // Basic packet, header-only packet, back-to-back len=1 packet, idle data_v.
      for (int i = 0; i < 10; i++) begin
         apply(vecs[i].hv, vecs[i].dest, vecs[i].len, vecs[i].user,
               vecs[i].dv, vecs[i].d, vecs[i].y);
         check($sformatf("vec%0d", i),
               {11'h0, link_v_o, link_data_o, hdr_ready_o, data_ready_o, pkt_done_o, busy_o},
               {11'h0, vecs[i].e_v, vecs[i].e_data, vecs[i].e_hr, vecs[i].e_dr,
                vecs[i].e_done, vecs[i].e_busy});
         tick();
      end

      // Four-cycle downstream stall in the middle of a body.
      cap.delete(); n_done = 0;
      apply(1'b1, 4'd1, 3'd3, 9'd1, 1'b0, 16'h0000, 1'b0);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'h1111, 1'b1);
      tick();
      repeat (4) begin
         apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'h2222, 1'b0);
         check("stall_data", {16'h0, link_data_o}, 32'h1111);
         check("stall_dready", {31'h0, data_ready_o}, 32'h0);
         tick();
      end
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'h2222, 1'b1);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'h3333, 1'b1);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0);
      tick();
      exp_q = '{16'h00B1, 16'h1111, 16'h2222, 16'h3333};
      check_cap("stall");
      check("stall_done", 32'(n_done), 32'd1);

      // Maximum-length packet with data_v_i toggling every cycle.
      cap.delete(); n_done = 0; n_data = 0;
      apply(1'b1, 4'd2, 3'd7, 9'd0, 1'b0, 16'h0000, 1'b0);
      tick();
      for (int k = 0; k < 40 && n_data < 7; k++) begin
         apply(1'b0, 4'd0, 3'd0, 9'd0, k[0], 16'h0100 + 16'(n_data), 1'b1);
         check("len7_hready_low", {31'h0, hdr_ready_o}, 32'h0);
         tick();
      end
      check("len7_data_hs", 32'(n_data), 32'd7);
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
      check("len7_hready_after", {31'h0, hdr_ready_o}, 32'h1);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0);
      tick();
      exp_q = '{16'h0072, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106};
      check_cap("len7");
      check("len7_done", 32'(n_done), 32'd1);

      // Asynchronous reset in the middle of a three-flit body.
      cap.delete();
      apply(1'b1, 4'd6, 3'd3, 9'd0, 1'b0, 16'h0000, 1'b0);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b1, 16'h5555, 1'b1);
      tick();
      check("pre_rst_v", {31'h0, link_v_o}, 32'h1);
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0);
      reset_n_i = 1'b0;
      #1;
      check("async_rst",
            {11'h0, link_v_o, link_data_o, busy_o, data_ready_o, hdr_ready_o, pkt_done_o}, 32'h0);
      @(posedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      apply(1'b1, 4'd7, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0);
      check("post_rst_hready", {31'h0, hdr_ready_o}, 32'h1);
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
      check("post_rst_flit", {15'h0, link_v_o, link_data_o}, {15'h0, 1'b1, 16'h0007});
      tick();
      apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b0);
      tick();

`ifdef BSG_WORMHOLE_PACKET_TX_STATS_EN
      reset_n_i = 1'b0;
      #1;
      check("stats_reset", {16'h0, pkt_count_o}, 32'h0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      repeat (3) begin
         apply(1'b1, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
         tick();
      end
      repeat (3) begin
         apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
         tick();
      end
      check("stats_three", {16'h0, pkt_count_o}, 32'd3);
      for (int p = 0; p < 65534; p++) begin
         apply(1'b1, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
         tick();
      end
      repeat (3) begin
         apply(1'b0, 4'd0, 3'd0, 9'd0, 1'b0, 16'h0000, 1'b1);
         tick();
      end
      check("stats_wrap", {16'h0, pkt_count_o}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
